nx_cdc_hs_tx: RTL and testbench

NX_CDC_HS_TX -- requirements
Module: nx_cdc_hs_tx

---
 rtl/nx_cdc_pkg.sv | 11 +
 rtl/nx_cdc_hs_tx.sv | 83 ++++++++
 tb/tb_nx_cdc_hs_tx.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nx_cdc_pkg.sv
// Shared types and constants for the toggle-handshake CDC transmitter.
package nx_cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } nx_cdc_state_e;

  localparam int NX_CDC_DEF_RANKS = 2;

endpackage

// File: rtl/nx_cdc_hs_tx.sv
// Source side of a two-phase (toggle) request/acknowledge clock-domain crossing.
// A payload is latched into xfer_data and xfer_req toggles; the block then waits
// until the synchronized acknowledge toggles to the same level before taking
// the next payload. An optional wait counter flags an overlong acknowledge wait.
module nx_cdc_hs_tx
  import nx_cdc_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_RANKS  = NX_CDC_DEF_RANKS,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             xfer_req,
  output logic [WIDTH-1:0] xfer_data,
  input  logic             xfer_ack,
  output logic             xfer_done,
  output logic             timeout_err
);

  // Counter value at which the timeout fires; only meaningful when enabled.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  localparam bit          TMO_EN   = (TIMEOUT_CYC != 0);

  nx_cdc_state_e         state;
  logic [SYNC_RANKS-1:0] ack_sync;
  logic                  ack_s;
  logic                  ack_match;
  logic                  accept;
  logic                  tmo_hit;
  logic [15:0]           wait_cnt;

  // Acknowledge synchronizer: xfer_ack is asynchronous, shift it through the chain.
  always_ff @(posedge clk) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_RANKS-2:0], xfer_ack};
  end

  assign ack_s     = ack_sync[SYNC_RANKS-1];
  // Levels equal means the far side has seen the latest toggle (or nothing is outstanding).
  assign ack_match = (ack_s == xfer_req);
  assign in_rdy    = (state == IDLE) && ack_match;
  assign accept    = in_vld && in_rdy;
  // Completion is reported in the cycle the match is seen; the FSM leaves WAIT_ACK on the closing edge.
  assign xfer_done = (state == WAIT_ACK) && ack_match;
  // A match in the timeout cycle wins: the transfer completed, so no error.
  assign tmo_hit   = TMO_EN && (state == WAIT_ACK) && !ack_match && (wait_cnt == TMO_LAST);

  // Handshake FSM with payload/request registers, wait counter and timeout pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      case (state)
        IDLE: begin
          if (accept) begin
            xfer_data <= in_data;
            xfer_req  <= ~xfer_req;
            wait_cnt  <= '0;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_match) begin
            state <= IDLE;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nx_cdc_hs_tx.sv
// Self-checking bench for nx_cdc_hs_tx: scoreboard of accepted payloads checked
// against completions, a payload table for streaming, and hand-written corner cases.
module tb_nx_cdc_hs_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld_a, in_vld_b;
  logic [31:0] in_data_a, in_data_b;
  logic        in_rdy_a, in_rdy_b;
  logic        req_a, req_b;
  logic [31:0] data_a, data_b;
  logic        ack_a, ack_b;
  logic        done_a, done_b;
  logic        terr_a, terr_b;
  logic        loop_a, ack_force_a;

  always #5 clk = ~clk;

  assign ack_a = loop_a ? req_a : ack_force_a;

  nx_cdc_hs_tx #(.WIDTH(32), .SYNC_RANKS(2), .TIMEOUT_CYC(10)) u_a (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld_a), .in_data(in_data_a), .in_rdy(in_rdy_a),
    .xfer_req(req_a), .xfer_data(data_a), .xfer_ack(ack_a), .xfer_done(done_a),
    .timeout_err(terr_a)
  );

  nx_cdc_hs_tx #(.WIDTH(32), .SYNC_RANKS(2), .TIMEOUT_CYC(5)) u_b (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld_b), .in_data(in_data_b), .in_rdy(in_rdy_b),
    .xfer_req(req_b), .xfer_data(data_b), .xfer_ack(ack_b), .xfer_done(done_b),
    .timeout_err(terr_b)
  );

  typedef struct {
    logic [31:0] data;
    int          gap;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] sb_q[$];
  int          acc_cyc = 0;
  int          prev_acc = 0;
  int          acc_cnt_a = 0;
  int          exp_lat = -1;
  int          terr_cnt_a = 0;
  int          terr_cyc_a = 0;
  int          done_cnt_b = 0;
  int          terr_cnt_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: note an accept before the edge, then sample outputs on the falling edge.
  task automatic tick();
    logic        acc;
    logic        rs;
    logic [31:0] exp;
    acc = in_vld_a && in_rdy_a && rst_n;
    rs  = rst_n;
    if (acc) sb_q.push_back(in_data_a);
    @(posedge clk);
    cyc++;
    if (acc) begin
      prev_acc = acc_cyc;
      acc_cyc  = cyc;
      acc_cnt_a++;
    end
    @(negedge clk);
    if (!rs) sb_q.delete();
    if (done_a) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done: got done=1 expected no pending transfer (cycle %0d)", cyc);
      end else begin
        exp = sb_q.pop_front();
        chk("done_data", data_a, exp);
        if (exp_lat >= 0) chk("done_lat", 32'(cyc - acc_cyc), 32'(exp_lat));
      end
    end else if (sb_q.size() != 0) begin
      chk("hold_data", data_a, sb_q[0]);
    end
    if (terr_a) begin
      terr_cnt_a++;
      terr_cyc_a = cyc;
    end
    if (done_b) done_cnt_b++;
    if (terr_b) terr_cnt_b++;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    vec_t tbl[4];
    int   n;
    int   a0;
    tbl[0] = '{32'd1, 0};
    tbl[1] = '{32'd2, 4};
    tbl[2] = '{32'd3, 4};
    tbl[3] = '{32'd4, 4};

    rst_n = 1'b0;
    in_vld_a = 1'b0; in_data_a = '0;
    in_vld_b = 1'b0; in_data_b = '0;
    loop_a = 1'b1; ack_force_a = 1'b0; ack_b = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_req", {31'd0, req_a}, 32'd0);
    chk("rst_data", data_a, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    chk("rst_terr", {31'd0, terr_a}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", {31'd0, in_rdy_a}, 32'd1);

    // Single transfer with loopback acknowledge
    exp_lat = 2;
    in_vld_a = 1'b1; in_data_a = 32'hDEADBEEF;
    tick();
    in_vld_a = 1'b0;
    chk("acc_req", {31'd0, req_a}, 32'd1);
    chk("acc_data", data_a, 32'hDEADBEEF);
    chk("acc_rdy_low", {31'd0, in_rdy_a}, 32'd0);
    drain("single_drain");
    chk("done_cyc_rdy_low", {31'd0, in_rdy_a}, 32'd0);
    tick();
    chk("rdy_back", {31'd0, in_rdy_a}, 32'd1);
    chk("rdy_back_lat", 32'(cyc - acc_cyc), 32'd3);
    chk("done_one_cycle", {31'd0, done_a}, 32'd0);

    // Streaming payloads with in_vld held high
    in_vld_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data_a = tbl[i].data;
      a0 = acc_cnt_a;
      n = 0;
      while (acc_cnt_a == a0 && n < 20) begin
        tick();
        n++;
      end
      chk("stream_acc", 32'(acc_cnt_a), 32'(a0 + 1));
      if (tbl[i].gap > 0) chk("stream_gap", 32'(acc_cyc - prev_acc), 32'(tbl[i].gap));
    end
    in_vld_a = 1'b0;
    drain("stream_drain");

    // Timeout with stuck acknowledge, then late acknowledge
    loop_a = 1'b0; ack_force_a = req_a;
    repeat (3) tick();
    exp_lat = -1;
    terr_cnt_a = 0;
    in_vld_a = 1'b1; in_data_a = 32'h55;
    tick();
    in_vld_a = 1'b0;
    n = 0;
    while (terr_cnt_a == 0 && n < 30) begin
      tick();
      n++;
    end
    chk("terr_lat", 32'(terr_cyc_a - acc_cyc), 32'd10);
    repeat (10) tick();
    chk("terr_once", 32'(terr_cnt_a), 32'd1);
    chk("terr_stay_wait", {31'd0, in_rdy_a}, 32'd0);
    chk("terr_pending", 32'(sb_q.size()), 32'd1);
    ack_force_a = req_a;
    drain("late_ack_drain");
    tick();
    chk("late_ack_idle", {31'd0, in_rdy_a}, 32'd1);

    // Stale acknowledge after reset blocks accepts
    rst_n = 1'b0; ack_force_a = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    in_vld_a = 1'b1; in_data_a = 32'h99;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stale_rdy", {31'd0, in_rdy_a}, 32'd0);
    end
    chk("stale_req", {31'd0, req_a}, 32'd0);
    chk("stale_no_acc", 32'(sb_q.size()), 32'd0);
    in_vld_a = 1'b0; ack_force_a = 1'b0;
    n = 0;
    while (!in_rdy_a && n < 10) begin
      tick();
      n++;
    end
    chk("stale_release_lat", 32'(n), 32'd2);

    // Reset in the middle of WAIT_ACK
    in_vld_a = 1'b1; in_data_a = 32'h1234;
    tick();
    in_vld_a = 1'b0;
    repeat (3) tick();
    chk("mid_wait_rdy", {31'd0, in_rdy_a}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req", {31'd0, req_a}, 32'd0);
    chk("mid_rst_data", data_a, 32'd0);
    chk("mid_rst_done", {31'd0, done_a}, 32'd0);
    chk("mid_rst_terr", {31'd0, terr_a}, 32'd0);
    chk("mid_rst_rdy", {31'd0, in_rdy_a}, 32'd1);
    rst_n = 1'b1; loop_a = 1'b1; exp_lat = 2;
    tick();
    in_vld_a = 1'b1; in_data_a = 32'hA5A5A5A5;
    tick();
    in_vld_a = 1'b0;
    chk("post_rst_data", data_a, 32'hA5A5A5A5);
    drain("post_rst_drain");

    // Acknowledge match lands on the timeout cycle (TIMEOUT_CYC=5)
    done_cnt_b = 0; terr_cnt_b = 0;
    in_vld_b = 1'b1; in_data_b = 32'h77;
    tick();
    in_vld_b = 1'b0;
    chk("b_acc_data", data_b, 32'h77);
    repeat (2) tick();
    ack_b = 1'b1;
    tick();
    chk("b_done_early", {31'd0, done_b}, 32'd0);
    tick();
    chk("b_done_on_tmo", {31'd0, done_b}, 32'd1);
    repeat (10) tick();
    chk("b_done_cnt", 32'(done_cnt_b), 32'd1);
    chk("b_terr_cnt", 32'(terr_cnt_b), 32'd0);
    chk("b_idle", {31'd0, in_rdy_b}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
